acc_cmd_arbiter: RTL and testbench
==================================

Name: acc_cmd_arbiter

Overview:
- Controller that shares one AdderAccumulator between two command requesters. Typical requesters: a button/switch front end, and a test-pattern or auto-step engine.
- Arbitrates round-robin and drives the accumulator's load/add strobes and data_in.
- Waits a programmable settle time, then returns the accumulator result to the granted requester with a one-cycle ack.
- Sits between the edge_to_pulse front ends and the accumulator in the board top level.

Parameters:
- WIDTH, 8, data width of operands and accumulator result
- SETTLE, 1, cycles from strobe to result capture; legal range 1..15

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 command request, level
- op0  input  1  requester 0 operation: 0 = load, 1 = add
- data0  input  WIDTH  requester 0 operand
- req1  input  1  requester 1 command request, level
- op1  input  1  requester 1 operation: 0 = load, 1 = add
- data1  input  WIDTH  requester 1 operand
- ack0  output  1  one-cycle completion pulse to requester 0
- ack1  output  1  one-cycle completion pulse to requester 1
- result  output  WIDTH  accumulator value captured for the last completed command
- busy  output  1  high whenever the FSM is not in IDLE
- acc_load  output  1  one-cycle load strobe to the accumulator
- acc_add  output  1  one-cycle add strobe to the accumulator
- acc_data  output  WIDTH  operand to the accumulator's data_in
- acc_q  input  WIDTH  accumulator data_out

Behaviour:
- Reset (async, immediate):
  - State IDLE; gnt = 0; last_grant = 1, so requester 0 wins the first tie.
  - Settle counter 0; result = 0.
  - ack0, ack1, busy, acc_load, acc_add = 0; acc_data = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK. Outputs are decoded from registered state (Moore); there are no combinational input-to-output paths.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it. If both are high, grant the requester that is not last_grant.
  - On grant: latch gnt, op and data from the granted port into internal registers, update last_grant, go to ISSUE. With no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - acc_data = latched operand.
  - acc_load = 1 if latched op = 0; acc_add = 1 if latched op = 1. The two strobes are never high together.
  - Load counter with SETTLE-1, go to WAIT.
- WAIT:
  - acc_data holds the latched operand; strobes are 0.
  - Counter decrements each cycle. At 0, capture result <= acc_q and go to ACK.
  - WAIT lasts exactly SETTLE cycles.
- ACK (exactly 1 cycle):
  - ack[gnt] = 1, the other ack = 0; result holds the captured value.
  - Return to IDLE.
- acc_data is 0 in IDLE and ACK.
- Latency:
  - req seen high at edge T → acc strobe during cycle T+1 → ack during cycle T+SETTLE+2.
  - Throughput: one command per SETTLE+3 cycles.
- Handshake:
  - Requester holds op/data stable only until the grant edge; they are latched there, so later changes are ignored.
  - req is level-sensitive. If req is still high in the IDLE cycle after ack, it is a new command.
  - Dropping req after the grant does not abort: the command completes and ack is still pulsed.
- Fairness:
  - With both reqs held high continuously, grants alternate 0,1,0,1.
  - A lone requester is granted back-to-back with no idle penalty beyond the IDLE cycle.
- Arithmetic: the controller performs none. The result is whatever acc_q shows, including modulo-2^WIDTH wrap from the accumulator.
- Reset mid-operation (ISSUE/WAIT/ACK):
  - Command is dropped and no ack is issued; all outputs return to reset values immediately.
  - First command after reset deassertion needs a fresh req in IDLE.
- SETTLE outside 1..15 is a configuration error; the bench checks the legal range only.

Test Plan:
- SETTLE=1, behavioural accumulator model, req0=1, op0=0, data0=0x12 for one cycle → acc_load high 1 cycle with acc_data=0x12; ack0 pulses 3 cycles after req sample; result=0x12; ack1 stays 0.
- Then req1=1, op1=1, data1=0x05 → acc_add pulse; ack1 pulses; result=0x17; busy high for exactly 3 cycles.
- From reset, req0 and req1 rise together (loads 0x01 and 0x02) → requester 0 served first (result 0x01, ack0), then requester 1 (result 0x02, ack1). Both reqs held high for 4 commands → grant order 0,1,0,1.
- Load 0xFF, then add 0x02 with SETTLE=3 → strobe-to-ack spacing of 4 cycles; result=0x01 (wrap).
- Assert reset during WAIT → ack0, ack1, busy, strobes and result go to 0 without waiting for a clock edge; no ack appears after release; next req is served normally.
- req0 dropped the cycle after grant, with data0 changed to 0xAA → the original operand is issued; ack0 still pulses; result reflects the original operand.

Source files
------------

// File: rtl/acc_cmd_arbiter.sv
// Round-robin command arbiter sharing one accumulator between two requesters.
// Issues a load/add strobe, waits SETTLE cycles, then returns the result with an ack.
module acc_cmd_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             acc_load,
    output logic             acc_add,
    output logic [WIDTH-1:0] acc_data,
    input  logic [WIDTH-1:0] acc_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_nx;
    logic             gnt;
    logic             gnt_nx;
    logic             last_grant;
    logic             last_nx;
    logic             op_q;
    logic             op_nx;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_nx;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_nx;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nx;
    logic             pick1;

    // On a tie, requester 1 wins only if requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            data_q     <= '0;
            cnt        <= '0;
            result_q   <= '0;
        end else begin
            state      <= state_nx;
            gnt        <= gnt_nx;
            last_grant <= last_nx;
            op_q       <= op_nx;
            data_q     <= data_nx;
            cnt        <= cnt_nx;
            result_q   <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        last_nx   = last_grant;
        op_nx     = op_q;
        data_nx   = data_q;
        cnt_nx    = cnt;
        result_nx = result_q;
        unique case (state)
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt_nx   = pick1;
                    last_nx  = pick1;
                    op_nx    = pick1 ? op1 : op0;
                    data_nx  = pick1 ? data1 : data0;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nx   = CNT_INIT;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    result_nx = acc_q;
                    state_nx  = S_ACK;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded purely from registered state.
    always_comb begin
        busy     = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        acc_data = '0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                busy = 1'b0;
            end
            (state == S_ISSUE): begin
                busy     = 1'b1;
                acc_load = ~op_q;
                acc_add  = op_q;
                acc_data = data_q;
            end
            (state == S_WAIT): begin
                busy     = 1'b1;
                acc_data = data_q;
            end
            (state == S_ACK): begin
                busy = 1'b1;
                ack0 = ~gnt;
                ack1 = gnt;
            end
        endcase
    end

    assign result = result_q;

endmodule

// File: tb/tb_acc_cmd_arbiter.sv
// Bench for acc_cmd_arbiter: two instances (SETTLE=1 and 3) share stimulus,
// each checked every cycle against a command-level timing model.
module tb_acc_cmd_arbiter;

    localparam int W  = 8;
    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic reset;
    logic req0;
    logic op0;
    logic [W-1:0] data0;
    logic req1;
    logic op1;
    logic [W-1:0] data1;

    logic         ack0_w [2];
    logic         ack1_w [2];
    logic         busy_w [2];
    logic         ld_w   [2];
    logic         add_w  [2];
    logic [W-1:0] res_w  [2];
    logic [W-1:0] accd_w [2];
    logic [W-1:0] accq0;
    logic [W-1:0] accq1;

    int checks = 0;
    int errors = 0;

    int           k    [2];
    int           sv   [2];
    int           last [2];
    int           g    [2];
    int           mop  [2];
    logic [W-1:0] md   [2];
    logic [W-1:0] macc [2];
    logic [W-1:0] mres [2];

    always #5 clk = ~clk;

    acc_cmd_arbiter #(.WIDTH(W), .SETTLE(S0)) u0 (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .data0(data0),
        .req1(req1), .op1(op1), .data1(data1),
        .ack0(ack0_w[0]), .ack1(ack1_w[0]),
        .result(res_w[0]), .busy(busy_w[0]),
        .acc_load(ld_w[0]), .acc_add(add_w[0]),
        .acc_data(accd_w[0]), .acc_q(accq0)
    );

    acc_cmd_arbiter #(.WIDTH(W), .SETTLE(S1)) u1 (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .data0(data0),
        .req1(req1), .op1(op1), .data1(data1),
        .ack0(ack0_w[1]), .ack1(ack1_w[1]),
        .result(res_w[1]), .busy(busy_w[1]),
        .acc_load(ld_w[1]), .acc_add(add_w[1]),
        .acc_data(accd_w[1]), .acc_q(accq1)
    );

    // Behavioural accumulators behind each instance.
    always @(posedge clk or posedge reset) begin
        if (reset) accq0 <= '0;
        else if (ld_w[0]) accq0 <= accd_w[0];
        else if (add_w[0]) accq0 <= accq0 + accd_w[0];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) accq1 <= '0;
        else if (ld_w[1]) accq1 <= accd_w[1];
        else if (add_w[1]) accq1 <= accq1 + accd_w[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i]    = 0;
            last[i] = 1;
            g[i]    = 0;
            mop[i]  = 0;
            md[i]   = '0;
            macc[i] = '0;
            mres[i] = '0;
        end
    endtask

    // k counts cycles since grant: 1 = strobe, 2..S+1 = settle, S+2 = ack.
    task automatic model_edge();
        int p;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (k[i] == 0) begin
                if (req0 || req1) begin
                    p = (req0 && req1) ? ((last[i] == 0) ? 1 : 0)
                                       : (req1 ? 1 : 0);
                    g[i]    = p;
                    last[i] = p;
                    mop[i]  = (p == 1) ? int'(op1) : int'(op0);
                    md[i]   = (p == 1) ? data1 : data0;
                    k[i]    = 1;
                end
            end else if (k[i] == 1) begin
                macc[i] = (mop[i] == 1) ? macc[i] + md[i] : md[i];
                k[i]    = 2;
            end else if (k[i] <= sv[i] + 1) begin
                if (k[i] == sv[i] + 1) mres[i] = macc[i];
                k[i] = k[i] + 1;
            end else begin
                k[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic e_ack, e_strobe;
        logic [W-1:0] e_data;
        for (int i = 0; i < 2; i++) begin
            e_ack    = (k[i] == sv[i] + 2);
            e_strobe = (k[i] == 1);
            e_data   = (k[i] >= 1 && k[i] <= sv[i] + 1) ? md[i] : '0;
            chk($sformatf("u%0d.ack0", i), ack0_w[i],
                e_ack && g[i] == 0);
            chk($sformatf("u%0d.ack1", i), ack1_w[i],
                e_ack && g[i] == 1);
            chk($sformatf("u%0d.busy", i), busy_w[i], k[i] != 0);
            chk($sformatf("u%0d.acc_load", i), ld_w[i],
                e_strobe && mop[i] == 0);
            chk($sformatf("u%0d.acc_add", i), add_w[i],
                e_strobe && mop[i] == 1);
            chk($sformatf("u%0d.acc_data", i), accd_w[i], e_data);
            chk($sformatf("u%0d.result", i), res_w[i], mres[i]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int bc;
        int acks;
        int ack_at;
        int order[$];
        logic [W-1:0] rres[$];

        sv[0] = S0;
        sv[1] = S1;
        reset = 1'b1;
        req0 = 0; op0 = 0; data0 = '0;
        req1 = 0; op1 = 0; data1 = '0;
        model_reset();
        #1;
        check_all();
        tick();
        reset = 1'b0;
        run(2);

        // Lone load on requester 0.
        req0 = 1; op0 = 0; data0 = 8'h12;
        tick();
        chk("u0.load_in_issue", ld_w[0], 1'b1);
        chk("u0.data_in_issue", accd_w[0], 8'h12);
        req0 = 0;
        tick();
        tick();
        chk("u0.ack0_at_T+3", ack0_w[0], 1'b1);
        chk("u0.ack1_quiet", ack1_w[0], 1'b0);
        run(4);
        chk("u0.result_load", res_w[0], 8'h12);
        chk("u1.result_load", res_w[1], 8'h12);

        // Add on requester 1; busy spans exactly SETTLE+2 cycles.
        req1 = 1; op1 = 1; data1 = 8'h05;
        tick();
        chk("u0.add_in_issue", add_w[0], 1'b1);
        req1 = 0;
        bc = 0;
        acks = 0;
        repeat (6) begin
            if (busy_w[0]) bc++;
            if (ack1_w[0]) acks++;
            tick();
        end
        chk("u0.busy_cycles", bc, 3);
        chk("u0.ack1_count", acks, 1);
        chk("u0.result_add", res_w[0], 8'h17);
        chk("u1.result_add", res_w[1], 8'h17);

        // Simultaneous requests from reset: alternation 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; op0 = 0; data0 = 8'h01;
        req1 = 1; op1 = 0; data1 = 8'h02;
        repeat (16) begin
            tick();
            if (ack0_w[0]) begin
                order.push_back(0);
                rres.push_back(res_w[0]);
            end
            if (ack1_w[0]) begin
                order.push_back(1);
                rres.push_back(res_w[0]);
            end
        end
        chk("rr.ack_count", order.size(), 4);
        for (int j = 0; j < order.size(); j++) begin
            chk($sformatf("rr.order%0d", j), order[j], j % 2);
            chk($sformatf("rr.result%0d", j), rres[j], (j % 2) + 1);
        end
        req0 = 0;
        req1 = 0;
        run(8);

        // Wrap: load 0xFF then add 0x02; strobe-to-ack spacing on SETTLE=3.
        req0 = 1; op0 = 0; data0 = 8'hFF;
        tick();
        req0 = 0;
        run(7);
        req1 = 1; op1 = 1; data1 = 8'h02;
        tick();
        chk("u1.add_strobe", add_w[1], 1'b1);
        req1 = 0;
        ack_at = -1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (ack1_w[1] && ack_at < 0) ack_at = j;
        end
        chk("u1.strobe_to_ack", ack_at, 4);
        chk("u0.result_wrap", res_w[0], 8'h01);
        chk("u1.result_wrap", res_w[1], 8'h01);

        // Asynchronous reset while in the settle wait.
        req0 = 1; op0 = 1; data0 = 8'h10;
        tick();
        req0 = 0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.rst_ack0", i), ack0_w[i], 1'b0);
            chk($sformatf("u%0d.rst_ack1", i), ack1_w[i], 1'b0);
            chk($sformatf("u%0d.rst_busy", i), busy_w[i], 1'b0);
            chk($sformatf("u%0d.rst_load", i), ld_w[i], 1'b0);
            chk($sformatf("u%0d.rst_add", i), add_w[i], 1'b0);
            chk($sformatf("u%0d.rst_data", i), accd_w[i], 8'h00);
            chk($sformatf("u%0d.rst_result", i), res_w[i], 8'h00);
        end
        model_reset();
        run(2);
        reset = 1'b0;
        run(6);
        req1 = 1; op1 = 0; data1 = 8'h5A;
        tick();
        req1 = 0;
        run(6);
        chk("u0.after_reset", res_w[0], 8'h5A);
        chk("u1.after_reset", res_w[1], 8'h5A);

        // Operand latched at grant; later changes ignored.
        req0 = 1; op0 = 0; data0 = 8'h33;
        tick();
        req0 = 0; op0 = 1; data0 = 8'hAA;
        run(6);
        chk("u0.latched_operand", res_w[0], 8'h33);
        chk("u1.latched_operand", res_w[1], 8'h33);

        // Random traffic against the model.
        repeat (400) begin
            req0  = 1'($urandom_range(0, 1));
            req1  = 1'($urandom_range(0, 1));
            op0   = 1'($urandom_range(0, 1));
            op1   = 1'($urandom_range(0, 1));
            data0 = W'($urandom);
            data1 = W'($urandom);
            tick();
        end
        req0 = 0;
        req1 = 0;
        run(8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
